// File: rtl/cam_byte_to_rgb565.sv
`default_nettype none
// ============================================================================
//  Module      : cam_byte_to_rgb565
//  Description : Pairs 8-bit camera bus bytes into RGB565 pixels with x/y
//                coordinates, frame/line markers and settle-frame skipping.
//  Revision    : 1.0  initial release
// ============================================================================
module cam_byte_to_rgb565 #(
  parameter int H_ACTIVE          = 640,
  parameter int V_ACTIVE          = 480,
  parameter int SKIP_FRAMES       = 2,
  parameter int FIRST_BYTE_HIGH   = 1,
  parameter int VSYNC_ACTIVE_HIGH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [15:0] rgb565,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        sof,
  output logic        eol,
  output logic        busy,
  output logic        line_err
);

  localparam logic        c_blank_lvl = (VSYNC_ACTIVE_HIGH != 0);
  localparam logic [10:0] c_h_active  = 11'(H_ACTIVE);
  localparam logic [10:0] c_h_last    = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  c_v_active  = 10'(V_ACTIVE);
  localparam logic [7:0]  c_skip_last = 8'(SKIP_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_v;
  logic        r_h;
  logic [7:0]  r_d;
  logic        r_blank_d;
  logic [7:0]  r_skip_cnt;
  logic        r_phase;
  logic [7:0]  r_hold;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic        r_line_pix;

  logic        w_blank;
  logic        w_boundary;

  assign w_blank    = (r_v == c_blank_lvl);
  assign w_boundary = w_blank & ~r_blank_d;

  // Previous blank level resets high so reset never fakes a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v       <= c_blank_lvl;
      r_h       <= 1'b0;
      r_d       <= 8'd0;
      r_blank_d <= 1'b1;
    end else begin
      r_v       <= cam_vsync;
      r_h       <= cam_href;
      r_d       <= cam_data;
      r_blank_d <= w_blank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_WAIT;
      r_skip_cnt <= 8'd0;
      r_phase    <= 1'b0;
      r_hold     <= 8'd0;
      r_x        <= 11'd0;
      r_y        <= 10'd0;
      r_line_pix <= 1'b0;
      rgb565     <= 16'd0;
      pix_valid  <= 1'b0;
      pix_x      <= 11'd0;
      pix_y      <= 10'd0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      busy       <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;

      case (r_state)
        ST_WAIT: begin
          if (w_boundary && capture_en) begin
            r_skip_cnt <= 8'd0;
            busy       <= 1'b1;
            r_state    <= (SKIP_FRAMES > 0) ? ST_SKIP : ST_CAPTURE;
          end
        end
        ST_SKIP: begin
          if (w_boundary) begin
            if (r_skip_cnt == c_skip_last) begin
              r_state <= ST_CAPTURE;
            end else begin
              r_skip_cnt <= r_skip_cnt + 8'd1;
            end
          end
        end
        ST_CAPTURE: begin
          if (w_boundary && !capture_en) begin
            r_state <= ST_WAIT;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_WAIT;
          busy    <= 1'b0;
        end
      endcase

      // A frame boundary outranks any href activity in the same cycle.
      if (w_boundary || (r_state != ST_CAPTURE)) begin
        r_phase    <= 1'b0;
        r_x        <= 11'd0;
        r_y        <= 10'd0;
        r_line_pix <= 1'b0;
      end else if (!w_blank) begin
        if (r_h) begin
          if (!r_phase) begin
            r_hold  <= r_d;
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if ((r_x < c_h_active) && (r_y < c_v_active)) begin
              rgb565     <= (FIRST_BYTE_HIGH != 0) ? {r_hold, r_d} : {r_d, r_hold};
              pix_valid  <= 1'b1;
              pix_x      <= r_x;
              pix_y      <= r_y;
              sof        <= (r_x == 11'd0) && (r_y == 10'd0);
              eol        <= (r_x == c_h_last);
              r_x        <= r_x + 11'd1;
              r_line_pix <= 1'b1;
            end else begin
              line_err <= 1'b1;
            end
          end
        end else begin
          // Line end: an unpaired byte is an orphan and is discarded.
          if (r_phase) begin
            line_err <= 1'b1;
          end
          if (r_line_pix) begin
            r_y <= r_y + 10'd1;
          end
          r_phase    <= 1'b0;
          r_x        <= 11'd0;
          r_line_pix <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cam_byte_to_rgb565.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_byte_to_rgb565
//  Description : Randomized frame-level bench for cam_byte_to_rgb565, two
//                parameterizations driven from one shared camera bus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cam_byte_to_rgb565;

  typedef struct packed {
    logic [15:0] rgb;
    logic [10:0] x;
    logic [9:0]  y;
    logic        sof;
    logic        eol;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture_en = 1'b0;
  logic        vs_blank = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        vs_b;

  logic [15:0] rgb  [2];
  logic [10:0] px   [2];
  logic [9:0]  py   [2];
  logic        pv   [2];
  logic        sofo [2];
  logic        eolo [2];
  logic        busy [2];
  logic        lerr [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model configuration: [0] small 4x4 frame, [1] VGA with skipping.
  int m_h    [2] = '{4, 640};
  int m_v    [2] = '{4, 480};
  int m_skip [2] = '{0, 2};
  int m_fbh  [2] = '{1, 0};
  int m_mode [2];
  int m_left [2];
  int m_row  [2];
  bit m_err  [2];

  pix_t       exp_q [2][$];
  pix_t       obs_q [2][$];
  int         obs_cyc[$];
  int         drv_cyc[$];
  logic [7:0] lb[$];

  assign vs_b = ~vs_blank;

  cam_byte_to_rgb565 #(
    .H_ACTIVE(4), .V_ACTIVE(4), .SKIP_FRAMES(0), .FIRST_BYTE_HIGH(1), .VSYNC_ACTIVE_HIGH(1)
  ) dut_a (
    .clk(clk), .rst(rst), .capture_en(capture_en), .cam_vsync(vs_blank),
    .cam_href(href), .cam_data(data), .rgb565(rgb[0]), .pix_valid(pv[0]),
    .pix_x(px[0]), .pix_y(py[0]), .sof(sofo[0]), .eol(eolo[0]),
    .busy(busy[0]), .line_err(lerr[0])
  );

  cam_byte_to_rgb565 #(
    .H_ACTIVE(640), .V_ACTIVE(480), .SKIP_FRAMES(2), .FIRST_BYTE_HIGH(0), .VSYNC_ACTIVE_HIGH(0)
  ) dut_b (
    .clk(clk), .rst(rst), .capture_en(capture_en), .cam_vsync(vs_b),
    .cam_href(href), .cam_data(data), .rgb565(rgb[1]), .pix_valid(pv[1]),
    .pix_x(px[1]), .pix_y(py[1]), .sof(sofo[1]), .eol(eolo[1]),
    .busy(busy[1]), .line_err(lerr[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pv[d] === 1'b1) begin
        obs_q[d].push_back({rgb[d], px[d], py[d], sofo[d], eolo[d]});
        if (d == 0) obs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model (frame / line granularity) -----------
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_left[d] = 0; m_row[d] = 0; m_err[d] = 1'b0;
    end
  endtask

  // mode: 0 idle, 1 discarding settle frames, 2 capturing
  task automatic model_boundary();
    for (int d = 0; d < 2; d++) begin
      m_row[d] = 0;
      if (m_mode[d] == 0) begin
        if (capture_en) begin
          if (m_skip[d] > 0) begin m_mode[d] = 1; m_left[d] = m_skip[d]; end
          else m_mode[d] = 2;
        end
      end else if (m_mode[d] == 1) begin
        m_left[d] = m_left[d] - 1;
        if (m_left[d] == 0) m_mode[d] = 2;
      end else if (!capture_en) begin
        m_mode[d] = 0;
      end
    end
  endtask

  task automatic model_line();
    for (int d = 0; d < 2; d++) begin
      if (m_mode[d] == 2) begin
        int n = lb.size();
        int np = n / 2;
        int emitted = 0;
        if ((n % 2) != 0) m_err[d] = 1'b1;
        if (np > m_h[d]) m_err[d] = 1'b1;
        if (m_row[d] >= m_v[d] && np > 0) m_err[d] = 1'b1;
        if (m_row[d] < m_v[d]) begin
          for (int p = 0; p < np && p < m_h[d]; p++) begin
            pix_t e;
            e.rgb = (m_fbh[d] != 0) ? {lb[2*p], lb[2*p+1]} : {lb[2*p+1], lb[2*p]};
            e.x   = 11'(p);
            e.y   = 10'(m_row[d]);
            e.sof = (p == 0) && (m_row[d] == 0);
            e.eol = (p == m_h[d] - 1);
            exp_q[d].push_back(e);
            emitted++;
          end
        end
        if (emitted > 0) m_row[d] = m_row[d] + 1;
      end
    end
  endtask

  // ---------------- stimulus ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      obs_q[d].delete();
    end
    obs_cyc.delete();
    drv_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; href = 1'b0; vs_blank = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic rand_line(input int min_pairs, input int max_pairs);
    lb.delete();
    repeat (2 * $urandom_range(max_pairs, min_pairs)) lb.push_back(8'($urandom));
  endtask

  task automatic send_line();
    for (int i = 0; i < lb.size(); i++) begin
      tick();
      href = 1'b1;
      data = lb[i];
      if ((i % 2) == 1) drv_cyc.push_back(cyc);
    end
    tick();
    href = 1'b0;
    data = 8'($urandom);
    repeat ($urandom_range(2, 0)) tick();
    model_line();
  endtask

  // Blank pulse; optionally toggles href inside it, which must be ignored.
  task automatic send_blank(input int n, input bit with_href);
    href = 1'b0;
    tick();
    vs_blank = 1'b1;
    model_boundary();
    repeat (n) tick();
    if (with_href) begin
      repeat (4) begin
        tick(); href = 1'b1; data = 8'($urandom);
      end
      tick(); href = 1'b0;
    end
    tick();
    vs_blank = 1'b0;
    tick();
  endtask

  task automatic send_frame(input int nlines);
    send_blank(2, 1'b0);
    repeat (nlines) begin
      rand_line(1, 4);
      send_line();
    end
  endtask

  task automatic flush();
    send_blank(2, 1'b0);
    repeat (4) tick();
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    clear_queues();
    capture_en = 1'b0;
    do_reset();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({rgb[d], pv[d], px[d], py[d], sofo[d], eolo[d], busy[d], lerr[d]} !== 42'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got rgb=%h pv=%b x=%0d y=%0d sof=%b eol=%b busy=%b err=%b, expected all zero",
                 d, rgb[d], pv[d], px[d], py[d], sofo[d], eolo[d], busy[d], lerr[d]);
      end
    end
  endtask

  task automatic test_frames();
    clear_queues();
    do_reset();
    capture_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      send_blank(2, 1'b0);
      lb = '{8'h12, 8'h34, 8'h12, 8'h34, 8'h12, 8'h34, 8'h12, 8'h34};
      send_line();
      repeat (2) begin
        rand_line(1, 4);
        send_line();
      end
    end
    flush();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (obs_q[d].size() !== exp_q[d].size()) begin
        n_fail++;
        $display("FAIL frames dut%0d pixel count: got %0d expected %0d", d, obs_q[d].size(), exp_q[d].size());
      end
      for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
        n_tests++;
        if (obs_q[d][i] !== exp_q[d][i]) begin
          n_fail++;
          $display("FAIL frames dut%0d pixel %0d: got %h expected %h", d, i, obs_q[d][i], exp_q[d][i]);
        end
      end
      n_tests++;
      if (lerr[d] !== m_err[d] || busy[d] !== (m_mode[d] != 0)) begin
        n_fail++;
        $display("FAIL frames dut%0d flags: got err=%b busy=%b expected err=%b busy=%b",
                 d, lerr[d], busy[d], m_err[d], m_mode[d] != 0);
      end
    end
  endtask

  task automatic test_errors();
    clear_queues();
    do_reset();
    capture_en = 1'b1;
    send_blank(2, 1'b0);
    lb.delete(); repeat (7) lb.push_back(8'($urandom)); send_line();
    lb.delete(); repeat (10) lb.push_back(8'($urandom)); send_line();
    repeat (3) begin rand_line(1, 1); send_line(); end
    rand_line(2, 2); send_line();
    flush();
    n_tests++;
    if (lerr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL errors line_err after bad lines: got %b expected 1", lerr[0]);
    end
    send_frame(3);
    flush();
    n_tests++;
    if (lerr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL errors line_err sticky: got %b expected 1", lerr[0]);
    end
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (obs_q[d].size() !== exp_q[d].size()) begin
        n_fail++;
        $display("FAIL errors dut%0d pixel count: got %0d expected %0d", d, obs_q[d].size(), exp_q[d].size());
      end
      for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
        n_tests++;
        if (obs_q[d][i] !== exp_q[d][i]) begin
          n_fail++;
          $display("FAIL errors dut%0d pixel %0d: got %h expected %h", d, i, obs_q[d][i], exp_q[d][i]);
        end
      end
      n_tests++;
      if (lerr[d] !== m_err[d]) begin
        n_fail++;
        $display("FAIL errors dut%0d line_err: got %b expected %b", d, lerr[d], m_err[d]);
      end
    end
  endtask

  task automatic test_capture_drop();
    clear_queues();
    do_reset();
    capture_en = 1'b1;
    send_frame(2);
    send_blank(2, 1'b0);
    rand_line(1, 4); send_line();
    capture_en = 1'b0;
    repeat (2) begin rand_line(1, 4); send_line(); end
    send_blank(2, 1'b1);
    n_tests++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_drop dut0 busy after boundary: got %b expected 0", busy[0]);
    end
    repeat (2) begin rand_line(1, 4); send_line(); end
    flush();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (obs_q[d].size() !== exp_q[d].size()) begin
        n_fail++;
        $display("FAIL capture_drop dut%0d pixel count: got %0d expected %0d", d, obs_q[d].size(), exp_q[d].size());
      end
      for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
        n_tests++;
        if (obs_q[d][i] !== exp_q[d][i]) begin
          n_fail++;
          $display("FAIL capture_drop dut%0d pixel %0d: got %h expected %h", d, i, obs_q[d][i], exp_q[d][i]);
        end
      end
      n_tests++;
      if (busy[d] !== (m_mode[d] != 0)) begin
        n_fail++;
        $display("FAIL capture_drop dut%0d final busy: got %b expected %b", d, busy[d], m_mode[d] != 0);
      end
    end
  endtask

  task automatic test_timing();
    clear_queues();
    do_reset();
    capture_en = 1'b1;
    send_blank(2, 1'b0);
    drv_cyc.delete();
    obs_cyc.delete();
    rand_line(4, 4);
    send_line();
    flush();
    n_tests++;
    if (obs_cyc.size() !== 4) begin
      n_fail++;
      $display("FAIL timing strobe count: got %0d expected 4", obs_cyc.size());
    end
    for (int i = 0; i < obs_cyc.size() && i < drv_cyc.size(); i++) begin
      n_tests++;
      if (obs_cyc[i] !== drv_cyc[i] + 2) begin
        n_fail++;
        $display("FAIL timing pixel %0d strobe edge: got %0d expected %0d", i, obs_cyc[i], drv_cyc[i] + 2);
      end
    end
    for (int i = 0; i < exp_q[0].size() && i < obs_q[0].size(); i++) begin
      n_tests++;
      if (obs_q[0][i] !== exp_q[0][i]) begin
        n_fail++;
        $display("FAIL timing pixel %0d value: got %h expected %h", i, obs_q[0][i], exp_q[0][i]);
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [7:0] b [8];
    pix_t e;
    clear_queues();
    do_reset();
    capture_en = 1'b1;
    send_blank(2, 1'b0);
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      tick(); href = 1'b1; data = b[i];
    end
    tick(); rst = 1'b1; data = b[4];
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({rgb[d], pv[d], px[d], py[d], sofo[d], eolo[d], busy[d], lerr[d]} !== 42'd0) begin
        n_fail++;
        $display("FAIL reset_midline dut%0d: got rgb=%h pv=%b x=%0d y=%0d sof=%b eol=%b busy=%b err=%b, expected all zero",
                 d, rgb[d], pv[d], px[d], py[d], sofo[d], eolo[d], busy[d], lerr[d]);
      end
    end
    rst = 1'b0;
    for (int i = 5; i < 8; i++) begin
      data = b[i]; tick();
    end
    href = 1'b0;
    tick();
    // Only the pair completed well before reset reaches the output.
    e.rgb = {b[0], b[1]}; e.x = 11'd0; e.y = 10'd0; e.sof = 1'b1; e.eol = 1'b0;
    exp_q[0].push_back(e);
    model_reset();
    send_frame(2);
    flush();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (obs_q[d].size() !== exp_q[d].size()) begin
        n_fail++;
        $display("FAIL reset_midline dut%0d pixel count: got %0d expected %0d", d, obs_q[d].size(), exp_q[d].size());
      end
      for (int i = 0; i < exp_q[d].size() && i < obs_q[d].size(); i++) begin
        n_tests++;
        if (obs_q[d][i] !== exp_q[d][i]) begin
          n_fail++;
          $display("FAIL reset_midline dut%0d pixel %0d: got %h expected %h", d, i, obs_q[d][i], exp_q[d][i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_errors();
    test_capture_drop();
    test_timing();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
